// File: rtl/parking_pkg.sv
// Shared constants and types for the parking sensor front end.
package parking_pkg;

  localparam int unsigned CLK_HZ                  = 40000000;
  // 10 ms of stable level at CLK_HZ
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
  localparam int unsigned SLOT_W                  = 2;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer, level debouncer and registered falling-edge event
// for one active-low sensor.
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic fall_event
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; the next mismatch toggles.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             event_q, event_d;

  // Count consecutive mismatching cycles; toggle the stable level when the count completes.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    event_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        // Only the 1->0 (car arrives) transition is an event
        event_d  = stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and event pulse; idle level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      event_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      event_q  <= event_d;
    end
  end

  assign fall_event = event_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions raw entry/exit sensors into level requests with ack handshake,
// captures the exit slot and counts events lost to a still-pending request.
module sensor_conditioner
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned DROP_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Entry_sensor,
  input  logic              Exit_sensor,
  input  logic [SLOT_W-1:0] Exit_parking,
  input  logic              entry_ack,
  input  logic              exit_ack,
  output logic              entry_req,
  output logic              exit_req,
  output slot_t             exit_slot,
  output logic [DROP_W-1:0] drop_cnt
);

  logic entry_event, exit_event;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_entry_db (
    .clk       (clk),
    .reset     (reset),
    .raw       (Entry_sensor),
    .fall_event(entry_event)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_exit_db (
    .clk       (clk),
    .reset     (reset),
    .raw       (Exit_sensor),
    .fall_event(exit_event)
  );

  slot_t             park_sync1_q, park_sync2_q;
  logic              entry_req_q, entry_req_d;
  logic              exit_req_q, exit_req_d;
  slot_t             exit_slot_q, exit_slot_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              entry_drop, exit_drop;
  logic [DROP_W:0]   drop_sum;

  // Request/ack handshake: a new event wins over a coincident ack; an event
  // against an unacknowledged request is dropped and counted.
  always_comb begin
    entry_drop = entry_event & entry_req_q & ~entry_ack;
    exit_drop  = exit_event & exit_req_q & ~exit_ack;

    entry_req_d = entry_req_q;
    if (entry_event)    entry_req_d = 1'b1;
    else if (entry_ack) entry_req_d = 1'b0;

    exit_req_d  = exit_req_q;
    exit_slot_d = exit_slot_q;
    if (exit_event && !exit_drop) begin
      exit_req_d  = 1'b1;
      exit_slot_d = park_sync2_q;
    end else if (!exit_event && exit_ack) begin
      exit_req_d  = 1'b0;
    end

    // One bit of headroom: at most two drops per cycle on an all-ones count
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_W+1)'(entry_drop) + (DROP_W+1)'(exit_drop);
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // Slot synchronizer and request/slot/drop state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      park_sync1_q <= '1;
      park_sync2_q <= '1;
      entry_req_q  <= 1'b0;
      exit_req_q   <= 1'b0;
      exit_slot_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      park_sync1_q <= Exit_parking;
      park_sync2_q <= park_sync1_q;
      entry_req_q  <= entry_req_d;
      exit_req_q   <= exit_req_d;
      exit_slot_q  <= exit_slot_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign entry_req = entry_req_q;
  assign exit_req  = exit_req_q;
  assign exit_slot = exit_slot_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench: stimulus queues the expected request-rise edge (and exit
// slot); a negedge monitor pops and compares whenever a request rises.
module tb_sensor_conditioner;

  localparam int unsigned DB  = 8;
  localparam int          LAT = DB + 3; // drive at negedge -> sampling edge +1, then DB+2 edges

  logic       clk = 1'b0;
  logic       reset;
  logic       Entry_sensor, Exit_sensor;
  logic [1:0] Exit_parking;
  logic       entry_ack, exit_ack;
  logic       entry_req, exit_req;
  logic [1:0] exit_slot;
  logic [7:0] drop_cnt;
  logic       entry_req_s, exit_req_s;
  logic [1:0] exit_slot_s;
  logic [1:0] drop_cnt_s;

  sensor_conditioner #(.DEBOUNCE_CYCLES(DB), .DROP_W(8)) dut (
    .clk(clk), .reset(reset), .Entry_sensor(Entry_sensor), .Exit_sensor(Exit_sensor),
    .Exit_parking(Exit_parking), .entry_ack(entry_ack), .exit_ack(exit_ack),
    .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot), .drop_cnt(drop_cnt)
  );

  sensor_conditioner #(.DEBOUNCE_CYCLES(DB), .DROP_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Entry_sensor(Entry_sensor), .Exit_sensor(Exit_sensor),
    .Exit_parking(Exit_parking), .entry_ack(entry_ack), .exit_ack(exit_ack),
    .entry_req(entry_req_s), .exit_req(exit_req_s), .exit_slot(exit_slot_s),
    .drop_cnt(drop_cnt_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] slot;
  } exit_exp_t;

  int        entry_exp_q[$];
  exit_exp_t exit_exp_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every request rise must match the oldest queued expectation
  logic entry_prev = 1'b0, exit_prev = 1'b0;
  always @(negedge clk) begin
    if (entry_req && !entry_prev) begin
      if (entry_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL entry_rise_unexpected: got rise at cycle %0d expected none", cyc);
      end else begin
        check("entry_rise_cycle", cyc, entry_exp_q.pop_front());
      end
    end
    if (exit_req && !exit_prev) begin
      if (exit_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL exit_rise_unexpected: got rise at cycle %0d expected none", cyc);
      end else begin
        exit_exp_t e;
        e = exit_exp_q.pop_front();
        check("exit_rise_cycle", cyc, e.cyc);
        check("exit_rise_slot", {30'd0, exit_slot}, {30'd0, e.slot});
      end
    end
    entry_prev = entry_req;
    exit_prev  = exit_req;
  end

  // One full entry event: low long enough to be accepted, then back high and stable
  task automatic entry_event(input bit expect_rise);
    Entry_sensor = 1'b0;
    if (expect_rise) entry_exp_q.push_back(cyc + LAT);
    tick(12);
    Entry_sensor = 1'b1;
    tick(12);
  endtask

  task automatic pulse_entry_ack();
    entry_ack = 1'b1; tick(1); entry_ack = 1'b0;
  endtask

  task automatic pulse_exit_ack();
    exit_ack = 1'b1; tick(1); exit_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; Entry_sensor = 1'b1; Exit_sensor = 1'b1;
    Exit_parking = 2'b00; entry_ack = 1'b0; exit_ack = 1'b0;
    tick(3);
    check("rst_entry_req", entry_req, 0);
    check("rst_exit_req", exit_req, 0);
    check("rst_exit_slot", exit_slot, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b1;
    tick(2);

    // Held-low entry: rise exactly 10 edges after first sample, ack clears next edge
    Entry_sensor = 1'b0;
    entry_exp_q.push_back(cyc + LAT);
    tick(20);
    check("entry_held_high", entry_req, 1);
    Entry_sensor = 1'b1;
    tick(12);
    check("entry_still_high", entry_req, 1);
    pulse_entry_ack();
    check("entry_ack_clear", entry_req, 0);
    pulse_entry_ack();
    check("entry_ack_when_low", entry_req, 0);

    // Glitch train: 5 low / 1 high never completes a debounce
    for (int i = 0; i < 50; i++) begin
      Entry_sensor = (i % 6 == 5);
      tick(1);
    end
    Entry_sensor = 1'b1;
    tick(12);
    check("glitch_no_req", entry_req, 0);
    check("glitch_no_drop", drop_cnt, 0);

    // Exit slot capture and hold
    Exit_parking = 2'b10;
    Exit_sensor  = 1'b0;
    exit_exp_q.push_back('{cyc: cyc + LAT, slot: 2'd2});
    tick(12);
    check("exit_req_high", exit_req, 1);
    check("exit_slot_2", exit_slot, 2);
    Exit_parking = 2'b01;
    tick(5);
    check("exit_slot_hold", exit_slot, 2);
    Exit_sensor = 1'b1;
    tick(12);
    check("exit_slot_hold2", exit_slot, 2);
    pulse_exit_ack();
    check("exit_ack_clear", exit_req, 0);
    check("exit_slot_after_ack", exit_slot, 2);
    Exit_sensor = 1'b0;
    exit_exp_q.push_back('{cyc: cyc + LAT, slot: 2'd1});
    tick(12);
    check("exit_slot_1", exit_slot, 1);
    Exit_sensor = 1'b1;
    tick(12);
    pulse_exit_ack();
    check("exit_ack_clear2", exit_req, 0);

    // Drops while pending, and saturation in the 2-bit instance
    entry_event(1'b1);
    entry_event(1'b0);
    entry_event(1'b0);
    check("drop_req_high", entry_req, 1);
    check("drop_cnt_2", drop_cnt, 2);
    check("drop_cnt_s_2", drop_cnt_s, 2);
    entry_event(1'b0);
    entry_event(1'b0);
    entry_event(1'b0);
    check("drop_cnt_5", drop_cnt, 5);
    check("drop_cnt_s_sat", drop_cnt_s, 3);
    pulse_entry_ack();
    check("drop_ack_clear", entry_req, 0);

    // Simultaneous entry and exit events
    Exit_parking = 2'b11;
    Entry_sensor = 1'b0;
    Exit_sensor  = 1'b0;
    entry_exp_q.push_back(cyc + LAT);
    exit_exp_q.push_back('{cyc: cyc + LAT, slot: 2'd3});
    tick(12);
    check("both_entry", entry_req, 1);
    check("both_exit", exit_req, 1);
    Entry_sensor = 1'b1;
    Exit_sensor  = 1'b1;
    tick(12);

    // Ack on the same edge as a new event keeps the request and loads the new slot
    Exit_parking = 2'b01;
    Entry_sensor = 1'b0;
    Exit_sensor  = 1'b0;
    tick(LAT - 1);
    entry_ack = 1'b1;
    exit_ack  = 1'b1;
    tick(1);
    entry_ack = 1'b0;
    exit_ack  = 1'b0;
    check("ackevt_entry", entry_req, 1);
    check("ackevt_exit", exit_req, 1);
    check("ackevt_slot", exit_slot, 1);
    check("ackevt_no_drop", drop_cnt, 5);
    Entry_sensor = 1'b1;
    Exit_sensor  = 1'b1;
    tick(12);
    pulse_entry_ack();
    pulse_exit_ack();
    check("ackevt_clear_entry", entry_req, 0);
    check("ackevt_clear_exit", exit_req, 0);

    // Reset mid-debounce at count 6 discards progress
    Entry_sensor = 1'b0;
    tick(8);
    reset = 1'b0;
    #1;
    check("midrst_entry", entry_req, 0);
    check("midrst_exit", exit_req, 0);
    check("midrst_slot", exit_slot, 0);
    check("midrst_drop", drop_cnt, 0);
    tick(1);
    reset = 1'b1;
    entry_exp_q.push_back(cyc + LAT);
    tick(14);
    check("midrst_req_after", entry_req, 1);
    check("midrst_drop_s", drop_cnt_s, 0);
    Entry_sensor = 1'b1;
    tick(12);

    check("entry_queue_empty", entry_exp_q.size(), 0);
    check("exit_queue_empty", exit_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
